// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life sequencer and board datapath.
package life_pkg;

    localparam int unsigned BOARD_W = 64;
    localparam int unsigned GEN_W   = 16;

    typedef logic [BOARD_W-1:0] board_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCRAMBLE = 3'd1,
        ST_LOAD     = 3'd2,
        ST_RUN      = 3'd3,
        ST_WAIT     = 3'd4
    } state_t;

    localparam board_t DEFAULT_SEED = 64'h0412_6424_0034_3C28;

    // Feedback taps at bits 63, 62, 60 and 59.
    localparam board_t LFSR_TAPS = 64'hD800_0000_0000_0000;

    // One left shift of the Fibonacci LFSR; feedback enters at bit 0.
    function automatic board_t lfsr_next(input board_t s);
        return {s[BOARD_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/life_sequencer_lfsr64.sv
// 64-bit Fibonacci LFSR with enable and synchronous seed load.
module lfsr64
    import life_pkg::*;
#(
    parameter board_t RESET_VAL = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic               i_load,
    input  logic [BOARD_W-1:0] i_seed,
    output logic [BOARD_W-1:0] o_state
);

    board_t r_state;

    // A load wins over a shift when both are requested in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESET_VAL;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/life_sequencer.sv
// Seeds the Game-of-Life board and paces generation updates via step_req/step_ack.
// Optional generation limit: define GEN_LIMIT_EN to stop with a done pulse at MAX_GEN.
module life_sequencer
    import life_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned MAX_GEN  = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_randomize,
    input  logic               i_stop,
    output logic               o_board_load,
    output logic [BOARD_W-1:0] o_board_data,
    output logic               o_step_req,
    input  logic               i_step_ack,
    output logic [GEN_W-1:0]   o_gen_count,
    output logic               o_running,
    output logic               o_done
);

    localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [TICK_W-1:0]  r_tick;
    logic [TICK_W-1:0]  w_tick_next;
    logic [GEN_W-1:0]   r_gen_count;
    logic [GEN_W-1:0]   w_gen_next;
    logic [GEN_W-1:0]   w_gen_inc;
    logic               r_stop_pending;
    logic               w_stop_pending_next;
    logic               r_board_load;
    logic               w_board_load_next;
    board_t             r_board_data;
    board_t             w_board_data_next;
    logic               r_step_req;
    logic               w_step_req_next;
    logic               r_running;
    logic               w_running_next;
    logic               r_done;
    logic               w_done_next;
    logic               w_lfsr_en;
    board_t             w_lfsr_state;
    logic               w_limit_hit;
    logic               w_done_on_exit;

    lfsr64 #(
        .RESET_VAL (DEFAULT_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_lfsr_en),
        .i_load  (1'b0),
        .i_seed  (DEFAULT_SEED),
        .o_state (w_lfsr_state)
    );

    assign w_gen_inc = r_gen_count + GEN_W'(1);

`ifdef GEN_LIMIT_EN
    localparam logic [GEN_W-1:0] GEN_MAX = GEN_W'(MAX_GEN);
    assign w_limit_hit    = (w_gen_inc == GEN_MAX);
    assign w_done_on_exit = 1'b1;
`else
    logic [GEN_W-1:0] w_unused_max_gen;
    assign w_unused_max_gen = GEN_W'(MAX_GEN);
    assign w_limit_hit      = 1'b0;
    assign w_done_on_exit   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_tick         <= '0;
            r_gen_count    <= '0;
            r_stop_pending <= 1'b0;
            r_board_load   <= 1'b0;
            r_board_data   <= '0;
            r_step_req     <= 1'b0;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_tick         <= w_tick_next;
            r_gen_count    <= w_gen_next;
            r_stop_pending <= w_stop_pending_next;
            r_board_load   <= w_board_load_next;
            r_board_data   <= w_board_data_next;
            r_step_req     <= w_step_req_next;
            r_running      <= w_running_next;
            r_done         <= w_done_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_tick_next         = r_tick;
        w_gen_next          = r_gen_count;
        w_stop_pending_next = r_stop_pending;
        w_board_load_next   = 1'b0;
        w_board_data_next   = r_board_data;
        w_done_next         = 1'b0;
        w_lfsr_en           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next      = ST_LOAD;
                    w_board_load_next = 1'b1;
                    w_board_data_next = DEFAULT_SEED;
                end else if (i_randomize) begin
                    w_state_next = ST_SCRAMBLE;
                end
            end
            ST_SCRAMBLE: begin
                // The shift on the exit edge is part of the captured pattern.
                w_lfsr_en = 1'b1;
                if (i_stop) begin
                    w_state_next = ST_IDLE;
                end else if (!i_randomize) begin
                    w_state_next      = ST_LOAD;
                    w_board_load_next = 1'b1;
                    w_board_data_next = lfsr_next(w_lfsr_state);
                end
            end
            ST_LOAD: begin
                w_state_next        = ST_RUN;
                w_gen_next          = '0;
                w_tick_next         = '0;
                w_stop_pending_next = 1'b0;
            end
            ST_RUN: begin
                if (i_stop) begin
                    w_state_next = ST_IDLE;
                    w_tick_next  = '0;
                end else if (r_tick == TICK_LAST) begin
                    w_state_next = ST_WAIT;
                    w_tick_next  = '0;
                end else begin
                    w_tick_next = r_tick + TICK_W'(1);
                end
            end
            ST_WAIT: begin
                // A stop here is remembered so the open request still completes.
                if (i_stop) begin
                    w_stop_pending_next = 1'b1;
                end
                if (i_step_ack) begin
                    w_gen_next          = w_gen_inc;
                    w_stop_pending_next = 1'b0;
                    if (r_stop_pending || i_stop || w_limit_hit) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = w_done_on_exit;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_step_req_next = (w_state_next == ST_WAIT);
        w_running_next  = (w_state_next == ST_RUN) || (w_state_next == ST_WAIT);
    end

    assign o_board_load = r_board_load;
    assign o_board_data = r_board_data;
    assign o_step_req   = r_step_req;
    assign o_gen_count  = r_gen_count;
    assign o_running    = r_running;
    assign o_done       = r_done;

endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer; expected values come from a behavioural model here.
module tb_life_sequencer;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned MAX_GEN  = 2;
    localparam logic [63:0] SEED     = 64'h0412_6424_0034_3C28;

    logic        clk;
    logic        reset;
    logic        start;
    logic        randomize;
    logic        stop;
    logic        step_ack;
    logic        board_load;
    logic [63:0] board_data;
    logic        step_req;
    logic [15:0] gen_count;
    logic        running;
    logic        done;

    int          checks;
    int          errors;
    logic [63:0] m_lfsr;
    int          m_gen;

    life_sequencer #(
        .TICK_DIV (TICK_DIV),
        .MAX_GEN  (MAX_GEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start),
        .i_randomize  (randomize),
        .i_stop       (stop),
        .o_board_load (board_load),
        .o_board_data (board_data),
        .o_step_req   (step_req),
        .i_step_ack   (step_ack),
        .o_gen_count  (gen_count),
        .o_running    (running),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference LFSR: shift left n times, new bit0 = b63^b62^b60^b59.
    function automatic logic [63:0] lfsr_adv(input logic [63:0] s, input int n);
        logic [63:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n, output bit ok);
        ok = 1'b0;
        n  = 200;
        for (int i = 0; i < 200; i++) begin
            if (step_req === 1'b1) begin
                ok = 1'b1;
                n  = i;
                return;
            end
            tick();
        end
    endtask

    // Holds the request open for lat cycles, then acknowledges it for one cycle.
    task automatic do_gen(input int lat, output bit held);
        held = 1'b1;
        for (int i = 0; i < lat; i++) begin
            tick();
            if (step_req !== 1'b1) held = 1'b0;
        end
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        m_gen = (m_gen + 1) % 65536;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        tick();
        tick();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; randomize = 1'b0; stop = 1'b0; step_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_lfsr = SEED;
        m_gen  = 0;
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        bit held;
        do_reset();
        checks++; if (board_load !== 1'b0) begin errors++; $display("FAIL rst_board_load: got %b want 0", board_load); end
        checks++; if (board_data !== 64'h0) begin errors++; $display("FAIL rst_board_data: got %h want 0", board_data); end
        checks++; if ({step_req, running, done} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b want 000", {step_req, running, done}); end
        checks++; if (gen_count !== 16'h0) begin errors++; $display("FAIL rst_gen: got %0d want 0", gen_count); end
        // Mid-run reset with a non-zero generation count.
        start = 1'b1; tick(); start = 1'b0;
        m_gen = 0;
        wait_req(n, ok);
        do_gen(0, held);
        tick();
        checks++; if (running !== 1'b1 || gen_count !== 16'd1) begin errors++; $display("FAIL rst_pre_run: got run=%b gen=%0d want run=1 gen=1", running, gen_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (board_data !== 64'h0 || board_load !== 1'b0) begin errors++; $display("FAIL rst_mid_data: got load=%b data=%h want 0/0", board_load, board_data); end
        checks++; if ({step_req, running, done} !== 3'b000 || gen_count !== 16'h0) begin errors++; $display("FAIL rst_mid_ctrl: got req/run/done=%b gen=%0d want 000/0", {step_req, running, done}, gen_count); end
        tick();
        reset = 1'b0;
        m_lfsr = SEED;
        m_gen  = 0;
        tick();
    endtask

    task automatic test_randomize();
        int k;
        logic [63:0] exp;
        logic [63:0] first_shift;
        bit quiet;
        first_shift = 64'h0824_C848_0068_7850;
        for (int c = 0; c < 5; c++) begin
            k = (c == 0) ? 1 : (c == 1) ? 10 : int'($urandom_range(2, 40));
            randomize = 1'b1;
            repeat (k) tick();
            randomize = 1'b0;
            tick();
            exp = lfsr_adv(m_lfsr, k);
            m_lfsr = exp;
            checks++; if (board_load !== 1'b1) begin errors++; $display("FAIL rand_load_k%0d: got %b want 1", k, board_load); end
            checks++; if (board_data !== exp) begin errors++; $display("FAIL rand_data_k%0d: got %h want %h", k, board_data, exp); end
            if (c == 0) begin
                checks++; if (board_data !== first_shift) begin errors++; $display("FAIL rand_first: got %h want %h", board_data, first_shift); end
            end
            stop_run();
            checks++; if (running !== 1'b0 || board_data !== exp) begin errors++; $display("FAIL rand_stop_k%0d: got run=%b data=%h want 0/%h", k, running, board_data, exp); end
        end
        // Stop during scramble: no load, but the LFSR keeps its shifts.
        randomize = 1'b1;
        repeat (3) tick();
        stop = 1'b1; randomize = 1'b0;
        tick();
        stop = 1'b0;
        m_lfsr = lfsr_adv(m_lfsr, 3);
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (board_load !== 1'b0 || running !== 1'b0) quiet = 1'b0;
            tick();
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL scramble_stop: got active outputs want idle"); end
    endtask

    task automatic test_start();
        int n;
        bit ok;
        bit held;
        bit quiet;
        start = 1'b1; tick(); start = 1'b0;
        m_gen = 0;
        checks++; if (board_load !== 1'b1 || board_data !== SEED) begin errors++; $display("FAIL start_load: got load=%b data=%h want 1/%h", board_load, board_data, SEED); end
        tick();
        checks++; if ({board_load, running, step_req} !== 3'b010) begin errors++; $display("FAIL start_run: got load/run/req=%b want 010", {board_load, running, step_req}); end
        wait_req(n, ok);
        checks++; if (!ok || n + 1 !== TICK_DIV + 1) begin errors++; $display("FAIL start_first_req: got %0d cycles want %0d", n + 1, TICK_DIV + 1); end
        do_gen(3, held);
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL start_req_held: got %b want 1", held); end
        checks++; if (step_req !== 1'b0 || gen_count !== 16'(m_gen)) begin errors++; $display("FAIL start_ack: got req=%b gen=%0d want 0/%0d", step_req, gen_count, m_gen); end
        // stop in RUN takes effect on the next edge.
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (running !== 1'b0 || step_req !== 1'b0) begin errors++; $display("FAIL run_stop: got run=%b req=%b want 0/0", running, step_req); end
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (step_req !== 1'b0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1 || board_data !== SEED) begin errors++; $display("FAIL run_stop_quiet: got quiet=%b data=%h want 1/%h", quiet, board_data, SEED); end
    endtask

    task automatic test_start_and_randomize();
        bit quiet;
        logic [63:0] exp;
        start = 1'b1; randomize = 1'b1; tick(); start = 1'b0; randomize = 1'b0;
        checks++; if (board_load !== 1'b1 || board_data !== SEED) begin errors++; $display("FAIL both_load: got load=%b data=%h want 1/%h", board_load, board_data, SEED); end
        tick();
        // start/randomize while running are ignored.
        start = 1'b1; randomize = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (board_load !== 1'b0 || running !== 1'b1) quiet = 1'b0;
        end
        start = 1'b0; randomize = 1'b0;
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL run_ignore: got disturbed run want undisturbed"); end
        stop = 1'b1; tick(); stop = 1'b0;
        randomize = 1'b1; tick(); randomize = 1'b0; tick();
        exp = lfsr_adv(m_lfsr, 1);
        m_lfsr = exp;
        checks++; if (board_load !== 1'b1 || board_data !== exp) begin errors++; $display("FAIL both_lfsr_kept: got %h want %h", board_data, exp); end
        stop_run();
    endtask

    task automatic test_stop_in_wait();
        int n;
        bit ok;
        bit held;
        logic exp_done;
`ifdef GEN_LIMIT_EN
        exp_done = 1'b1;
`else
        exp_done = 1'b0;
`endif
        start = 1'b1; tick(); start = 1'b0;
        m_gen = 0;
        wait_req(n, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wait_req_timeout: got %b want 1", ok); end
        stop = 1'b1; tick(); stop = 1'b0;
        held = (step_req === 1'b1) && (running === 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (step_req !== 1'b1 || running !== 1'b1) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL wait_stop_held: got %b want 1", held); end
        step_ack = 1'b1; tick(); step_ack = 1'b0;
        m_gen = m_gen + 1;
        checks++; if ({step_req, running} !== 2'b00 || gen_count !== 16'(m_gen)) begin errors++; $display("FAIL wait_stop_ack: got req/run=%b gen=%0d want 00/%0d", {step_req, running}, gen_count, m_gen); end
        checks++; if (done !== exp_done) begin errors++; $display("FAIL wait_stop_done: got %b want %b", done, exp_done); end
        tick();
        checks++; if (done !== 1'b0 || step_req !== 1'b0) begin errors++; $display("FAIL wait_stop_after: got done=%b req=%b want 0/0", done, step_req); end
        // ack in IDLE and in RUN must not count.
        step_ack = 1'b1; repeat (3) tick(); step_ack = 1'b0;
        checks++; if (gen_count !== 16'(m_gen) || running !== 1'b0) begin errors++; $display("FAIL ack_idle: got gen=%0d run=%b want %0d/0", gen_count, running, m_gen); end
        start = 1'b1; tick(); start = 1'b0; tick();
        m_gen = 0;
        step_ack = 1'b1; tick(); tick(); step_ack = 1'b0;
        checks++; if (gen_count !== 16'(m_gen) || step_req !== 1'b0) begin errors++; $display("FAIL ack_run: got gen=%0d req=%b want %0d/0", gen_count, step_req, m_gen); end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

`ifdef GEN_LIMIT_EN
    task automatic test_gen_limit();
        int n;
        bit ok;
        bit held;
        start = 1'b1; tick(); start = 1'b0;
        m_gen = 0;
        wait_req(n, ok);
        do_gen(0, held);
        checks++; if (gen_count !== 16'd1 || done !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL limit_first: got gen=%0d done=%b run=%b want 1/0/1", gen_count, done, running); end
        wait_req(n, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL limit_req_timeout: got %b want 1", ok); end
        do_gen(0, held);
        checks++; if (gen_count !== 16'(MAX_GEN) || done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL limit_hit: got gen=%0d done=%b run=%b want %0d/1/0", gen_count, done, running, MAX_GEN); end
        tick();
        checks++; if (done !== 1'b0 || step_req !== 1'b0) begin errors++; $display("FAIL limit_after: got done=%b req=%b want 0/0", done, step_req); end
    endtask
`else
    task automatic test_back_to_back();
        int n;
        int lat;
        bit ok;
        bit held;
        bit done_seen;
        start = 1'b1; tick(); start = 1'b0;
        m_gen = 0;
        done_seen = 1'b0;
        wait_req(n, ok);
        for (int g = 0; g < 20; g++) begin
            lat = int'($urandom_range(0, 6));
            do_gen(lat, held);
            if (done !== 1'b0) done_seen = 1'b1;
            checks++; if (held !== 1'b1 || gen_count !== 16'(m_gen)) begin errors++; $display("FAIL b2b_gen%0d: got held=%b gen=%0d want 1/%0d", g, held, gen_count, m_gen); end
            wait_req(n, ok);
            checks++; if (!ok || lat + 1 + n !== TICK_DIV + lat + 1) begin errors++; $display("FAIL b2b_spacing%0d: got %0d want %0d", g, lat + 1 + n, TICK_DIV + lat + 1); end
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL b2b_done: got 1 want 0"); end
        stop = 1'b1; step_ack = 1'b1; tick(); stop = 1'b0; step_ack = 1'b0;
        m_gen = m_gen + 1;
        checks++; if (running !== 1'b0 || gen_count !== 16'(m_gen)) begin errors++; $display("FAIL b2b_end: got run=%b gen=%0d want 0/%0d", running, gen_count, m_gen); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; start = 1'b0; randomize = 1'b0; stop = 1'b0; step_ack = 1'b0;
        m_lfsr = SEED;
        m_gen  = 0;
        test_reset();
        test_randomize();
        test_start();
        test_start_and_randomize();
        test_stop_in_wait();
`ifdef GEN_LIMIT_EN
        test_gen_limit();
`else
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_sequencer.md
# life_sequencer

Top-level controller for the 8x8 Game-of-Life board datapath. It selects the initial 64-bit pattern, either the fixed default seed or a free-running LFSR value captured on user request, and loads it into the board. It then paces generation updates with a programmable tick divider and a request/acknowledge handshake, and counts completed generations. It sits between the debounced user inputs (start/randomize/stop) and the board-update datapath.

## Interface
Parameters:
- TICK_DIV, default 25_000_000: clocks per generation period in RUN; must be ≥ 2.
- MAX_GEN, default 1000: generation limit; only used when GEN_LIMIT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; load the default seed and run.
- randomize  in  1  level; scramble the LFSR while held, then load its value and run.
- stop  in  1  level; return to IDLE.
- board_load  out  1  one-cycle strobe; board captures board_data.
- board_data  out  64  pattern to load; valid while board_load is high.
- step_req  out  1  request one generation update.
- step_ack  in  1  datapath has finished the update.
- gen_count  out  16  completed generations since the last load.
- running  out  1  high in RUN and WAIT.
- done  out  1  one-cycle pulse at the generation limit (GEN_LIMIT_EN only; otherwise tied 0).

## Operation
- States: IDLE, SCRAMBLE, LOAD, RUN, WAIT.
- IDLE:
  - start → LOAD with pattern = DEFAULT_SEED (64'h0412_6424_0034_3C28).
  - Otherwise randomize → SCRAMBLE.
  - start has priority when start and randomize are both high.
- SCRAMBLE:
  - LFSR advances one shift per clock.
  - On randomize low → LOAD with pattern = current LFSR value.
  - stop → IDLE.
- LFSR:
  - 64-bit Fibonacci, shifts left; bit0 ← b63^b62^b60^b59.
  - Reset value DEFAULT_SEED; holds its value outside SCRAMBLE.
- LOAD: lasts exactly one cycle; board_load=1, gen_count cleared to 0, tick counter cleared → RUN.
- RUN:
  - Tick counter counts 0..TICK_DIV-1.
  - At TICK_DIV-1 → WAIT; counter clears.
  - stop → IDLE immediately.
- WAIT:
  - step_req=1, held until step_ack is sampled high.
  - On ack: gen_count increments, wrapping at 16 bits → RUN.
  - stop in WAIT is latched; FSM goes → IDLE on ack, never abandoning an open request.
- step_ack outside WAIT is ignored.
- start or randomize while running is ignored.
- Reset mid-operation: all state returns to reset values in the same cycle.

## Timing
- All outputs are registered.
- Reset values: board_load=0, board_data=0, step_req=0, gen_count=0, running=0, done=0, state=IDLE, LFSR=DEFAULT_SEED.
- start sampled high at edge N → board_load=1 during cycle N+1 only.
- First step_req rises TICK_DIV cycles after the LOAD cycle.
- step_req falls in the cycle after step_ack is sampled; gen_count updates on that same edge.
- Request-to-request spacing = TICK_DIV + ack latency + 1 cycle.
- board_data holds its last loaded pattern after LOAD.

## Configuration
- GEN_LIMIT_EN defined:
  - On the ack that makes gen_count == MAX_GEN: done pulses for one cycle and FSM → IDLE.
  - A pending stop gives the same transition and also pulses done.
- GEN_LIMIT_EN undefined: runs until stop; gen_count wraps 16'hFFFF→0; done is constant 0.

## Structure
- Package life_pkg:
  - state enum typedef (logic [2:0]).
  - DEFAULT_SEED constant.
  - LFSR tap constant.
  - 64-bit board type.
- Sub-module lfsr64: enable, synchronous seed load, 64-bit state output. Also reused by the board datapath for noise injection.

## Test plan
- Reset mid-RUN (TICK_DIV=4) → all outputs 0, state IDLE, LFSR = 64'h0412_6424_0034_3C28.
- start pulse → board_load high 1 cycle with board_data=64'h0412_6424_0034_3C28; step_req rises 4 cycles after LOAD; ack after 3 cycles → gen_count=1, step_req falls next cycle.
- randomize high exactly 1 cycle → board_data=64'h0824_C848_0068_7850; 10 cycles → matches the reference LFSR model.
- start and randomize rise together → default seed loaded, LFSR unchanged.
- stop asserted in WAIT, ack 5 cycles later → step_req held until ack, then IDLE with running=0; stop in RUN → IDLE next cycle, no step_req.
- GEN_LIMIT_EN, MAX_GEN=2, immediate acks → done pulses on 2nd ack, gen_count=2, state IDLE; without the macro, 65536 acks → gen_count wraps to 0.
